cpu_path_sequencer: RTL

Host-side controller that sequences a `t2b_riscv_cpu` path-planning run. It holds the CPU in reset and preloads the four mailbox words through the CPU's external memory-write port: START_POINT, END_POINT, NODE_POINT and CPU_DONE. It then releases the CPU, captures every NODE_POINT the CPU writes into an on-chip FIFO, and ends the run on CPU_DONE or on a watchdog timeout.

---
 rtl/cpu_path_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_path_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_path_sequencer
// Host-side controller for one path-planning run of a RISC-V CPU. It holds the
// CPU in reset while it preloads the four mailbox words (SP, EP, NODE_POINT,
// CPU_DONE) through the CPU's external write port. It then releases the CPU
// and captures every NODE_POINT store into a show-ahead FIFO. The run ends on
// a CPU_DONE store of 1, or when the watchdog expires.
//
// Ports
//   clk, reset                    : clock, asynchronous active-high reset
//   start, start_point, end_point : run request and the SP/EP node indices
//   cpu_reset                     : drives the CPU reset input
//   Ext_MemWrite/WriteData/DataAdr: preload write port into the CPU memory
//   MemWrite/WriteData/DataAdr    : CPU store bus (monitored only)
//   node_rd, node_data, node_empty, node_count, node_overflow : node FIFO
//   busy, done, timeout           : run status
// ---------------------------------------------------------------------------
module cpu_path_sequencer #(
  parameter logic [31:0] MBOX_BASE      = 32'h0200_0000,
  parameter int          NODE_DEPTH     = 32,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [4:0]                      start_point,
  input  logic [4:0]                      end_point,
  output logic                            cpu_reset,
  output logic                            Ext_MemWrite,
  output logic [31:0]                     Ext_WriteData,
  output logic [31:0]                     Ext_DataAdr,
  input  logic                            MemWrite,
  input  logic [31:0]                     WriteData,
  input  logic [31:0]                     DataAdr,
  input  logic                            node_rd,
  output logic [4:0]                      node_data,
  output logic                            node_empty,
  output logic [$clog2(NODE_DEPTH+1)-1:0] node_count,
  output logic                            node_overflow,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout
);

  localparam int PTR_W = $clog2(NODE_DEPTH);
  localparam int CNT_W = $clog2(NODE_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_W_SP = 4'd1, S_G_SP = 4'd2, S_W_EP = 4'd3,
    S_G_EP = 4'd4, S_W_NP = 4'd5, S_G_NP = 4'd6, S_W_DN = 4'd7,
    S_G_DN = 4'd8, S_RUN  = 4'd9, S_DONE = 4'd10, S_TIMEOUT = 4'd11
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [4:0]         r_ep;
  logic [WD_W-1:0]    r_wd;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [4:0]         r_mem [NODE_DEPTH];

  logic w_parked;
  logic w_accept;
  logic w_node_wr;
  logic w_done_wr;
  logic w_wd_hit;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Start is only honoured while the CPU is parked in reset.
  assign w_parked  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_accept  = w_parked && start;
  assign w_node_wr = (r_state == S_RUN) && MemWrite && (DataAdr == MBOX_BASE + 32'h8);
  assign w_done_wr = (r_state == S_RUN) && MemWrite && (DataAdr == MBOX_BASE + 32'hc)
                     && (WriteData == 32'd1);
  assign w_wd_hit  = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_full    = (r_count == CNT_W'(NODE_DEPTH));
  assign w_pop     = node_rd && (r_count != {CNT_W{1'b0}});
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_push    = w_node_wr && (!w_full || w_pop);
  assign w_drop    = w_node_wr && w_full && !w_pop;
  assign node_count = r_count;

  // Next-state selection; DONE takes priority over the watchdog in RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) w_next_state = S_W_SP;
        else       w_next_state = r_state;
      end
      S_W_SP: w_next_state = S_G_SP;
      S_G_SP: w_next_state = S_W_EP;
      S_W_EP: w_next_state = S_G_EP;
      S_G_EP: w_next_state = S_W_NP;
      S_W_NP: w_next_state = S_G_NP;
      S_G_NP: w_next_state = S_W_DN;
      S_W_DN: w_next_state = S_G_DN;
      S_G_DN: w_next_state = S_RUN;
      S_RUN: begin
        if (w_done_wr)     w_next_state = S_DONE;
        else if (w_wd_hit) w_next_state = S_TIMEOUT;
        else               w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Sequencer state plus all run-control outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ep          <= 5'd0;
      cpu_reset     <= 1'b1;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= 32'd0;
      Ext_DataAdr   <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      if (w_accept) r_ep <= end_point;
      cpu_reset <= (w_next_state != S_RUN);
      busy      <= !((w_next_state == S_IDLE) || (w_next_state == S_DONE)
                     || (w_next_state == S_TIMEOUT));
      done      <= (w_next_state == S_DONE);
      timeout   <= (w_next_state == S_TIMEOUT);
      case (w_next_state)
        // W_SP is only reached from the accepting edge, so SP comes straight from the port.
        S_W_SP: begin
          Ext_MemWrite  <= 1'b1;
          Ext_WriteData <= {27'd0, start_point};
          Ext_DataAdr   <= MBOX_BASE;
        end
        S_W_EP: begin
          Ext_MemWrite  <= 1'b1;
          Ext_WriteData <= {27'd0, r_ep};
          Ext_DataAdr   <= MBOX_BASE + 32'h4;
        end
        S_W_NP: begin
          Ext_MemWrite  <= 1'b1;
          Ext_WriteData <= 32'd0;
          Ext_DataAdr   <= MBOX_BASE + 32'h8;
        end
        S_W_DN: begin
          Ext_MemWrite  <= 1'b1;
          Ext_WriteData <= 32'd0;
          Ext_DataAdr   <= MBOX_BASE + 32'hc;
        end
        default: begin
          Ext_MemWrite  <= 1'b0;
          Ext_WriteData <= 32'd0;
          Ext_DataAdr   <= 32'd0;
        end
      endcase
    end
  end

  // Watchdog: zero on RUN entry, counts each RUN cycle that stays in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd <= {WD_W{1'b0}};
    end else if ((r_state == S_RUN) && (w_next_state == S_RUN)) begin
      r_wd <= r_wd + WD_W'(1);
    end else begin
      r_wd <= {WD_W{1'b0}};
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO pointers, flags and the registered show-ahead head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      node_empty    <= 1'b1;
      node_data     <= 5'd0;
      node_overflow <= 1'b0;
    end else if (w_accept) begin
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      node_empty    <= 1'b1;
      node_data     <= 5'd0;
      node_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop) node_overflow <= 1'b1;
      r_count    <= w_count_next;
      node_empty <= (w_count_next == {CNT_W{1'b0}});
      // The head is either the next stored entry or, when the FIFO drains
      // to the incoming word, that word bypassed from the store bus.
      if (w_pop) begin
        if (r_count == CNT_W'(1)) node_data <= w_push ? WriteData[4:0] : 5'd0;
        else                      node_data <= r_mem[r_rd_ptr + PTR_W'(1)];
      end else if ((r_count == {CNT_W{1'b0}}) && w_push) begin
        node_data <= WriteData[4:0];
      end
    end
  end

  // Node storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= WriteData[4:0];
  end

endmodule
